// File: rtl/ctrl_sequencer.sv
// Multicycle control sequencer: accepts one 6-bit instruction, decodes it through an external ROM,
// issues the control word to the datapath with valid/ready, strobes writeback, and traps on faults.
module ctrl_sequencer #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [5:0]       instr,
  output logic             instr_ready,
  output logic [5:0]       rom_addr,
  input  logic [5:0]       rom_data,
  output logic             exec_valid,
  output logic [5:0]       exec_ctrl,
  input  logic             exec_ready,
  output logic             wb_en,
  output logic [1:0]       wb_sel,
  output logic             busy,
  output logic             trap,
  output logic [1:0]       trap_code,
  input  logic             trap_clr,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam int unsigned WaitW = $clog2(TIMEOUT);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StDecode, StExec, StWb, StTrap} state_e;

  state_e           state_q, state_d;
  logic [5:0]       instr_q, instr_d;
  logic [5:0]       ctrl_q, ctrl_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [1:0]       trap_code_q, trap_code_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic             instr_ready_q, exec_valid_q, wb_en_q, busy_q, trap_q;
  logic [5:0]       exec_ctrl_q;
  logic [1:0]       wb_sel_q;

  logic             legal;
  logic             needs_wb;
  logic             retire;

  // Legality comes from the registered instruction: the ROM output is undefined on illegal codes.
  always_comb begin
    legal = (instr_q[5:3] == 3'b000) ||
            (instr_q == 6'b001100) || (instr_q == 6'b010001) || (instr_q == 6'b011001) ||
            (instr_q == 6'b010101) || (instr_q == 6'b011101);
  end

  assign needs_wb = (ctrl_q[3:0] == 4'b0001) || (ctrl_q[3:0] == 4'b0011);

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    ctrl_d      = ctrl_q;
    wait_d      = wait_q;
    trap_code_d = trap_code_q;
    retire      = 1'b0;
    case (state_q)
      StIdle: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = StDecode;
        end
      end
      StDecode: begin
        wait_d = '0;
        if (legal) begin
          ctrl_d  = rom_data;
          state_d = StExec;
        end else begin
          trap_code_d = 2'b01;
          state_d     = StTrap;
        end
      end
      StExec: begin
        if (exec_ready) begin
          if (needs_wb) begin
            state_d = StWb;
          end else begin
            retire  = 1'b1;
            state_d = StIdle;
          end
        end else if (wait_q == WaitLast) begin
          trap_code_d = 2'b10;
          state_d     = StTrap;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StWb: begin
        retire  = 1'b1;
        state_d = StIdle;
      end
      StTrap: begin
        if (trap_clr) begin
          trap_code_d = 2'b00;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;

  // Outputs are registered from the next state so they change exactly with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      instr_q       <= '0;
      ctrl_q        <= '0;
      wait_q        <= '0;
      trap_code_q   <= 2'b00;
      retired_q     <= '0;
      instr_ready_q <= 1'b1;
      exec_valid_q  <= 1'b0;
      exec_ctrl_q   <= '0;
      wb_en_q       <= 1'b0;
      wb_sel_q      <= 2'b00;
      busy_q        <= 1'b0;
      trap_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      ctrl_q        <= ctrl_d;
      wait_q        <= wait_d;
      trap_code_q   <= trap_code_d;
      retired_q     <= retired_d;
      instr_ready_q <= (state_d == StIdle);
      exec_valid_q  <= (state_d == StExec);
      exec_ctrl_q   <= (state_d == StExec) ? ctrl_d : '0;
      wb_en_q       <= (state_d == StWb);
      wb_sel_q      <= (state_d == StWb) ? ctrl_d[5:4] : 2'b00;
      busy_q        <= (state_d != StIdle);
      trap_q        <= (state_d == StTrap);
    end
  end

  assign instr_ready = instr_ready_q;
  assign rom_addr    = instr_q;
  assign exec_valid  = exec_valid_q;
  assign exec_ctrl   = exec_ctrl_q;
  assign wb_en       = wb_en_q;
  assign wb_sel      = wb_sel_q;
  assign busy        = busy_q;
  assign trap        = trap_q;
  assign trap_code   = trap_code_q;
  assign retired_cnt = retired_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: directed table, hand-written corner sequences,
// and randomized transactions checked against a transaction-level model.
module tb_ctrl_sequencer;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             instr_valid;
  logic [5:0]       instr;
  logic             instr_ready;
  logic [5:0]       rom_addr;
  logic [5:0]       rom_data;
  logic             exec_valid;
  logic [5:0]       exec_ctrl;
  logic             exec_ready;
  logic             wb_en;
  logic [1:0]       wb_sel;
  logic             busy;
  logic             trap;
  logic [1:0]       trap_code;
  logic             trap_clr;
  logic [CNT_W-1:0] retired_cnt;

  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] exp_retired;

  typedef struct {
    logic [5:0] instr;
    int         delay;
    logic       exp_trap;
    logic [1:0] exp_code;
    int         exp_exec;
    logic       exp_wb;
    logic [1:0] exp_sel;
    logic [5:0] exp_ctrl;
  } vec_t;

  typedef struct {
    logic       done;
    logic [5:0] rom_addr;
    logic [5:0] ctrl;
    logic       unstable;
    int         exec_cycles;
    int         wb_cnt;
    logic [1:0] wb_sel;
    logic       trap;
    logic [1:0] trap_code;
    int         cycles;
    logic [7:0] retired;
  } obs_t;

  ctrl_sequencer #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_ready(instr_ready),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .exec_valid (exec_valid),
    .exec_ctrl  (exec_ctrl),
    .exec_ready (exec_ready),
    .wb_en      (wb_en),
    .wb_sel     (wb_sel),
    .busy       (busy),
    .trap       (trap),
    .trap_code  (trap_code),
    .trap_clr   (trap_clr),
    .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  // ROM model: {reg field, micro-op}; opcode 0000 -> sum, 0001 -> sub, one special entry.
  function automatic logic [5:0] rom_model(input logic [5:0] a);
    logic [3:0] uop;
    if (a == 6'b010001) return 6'b001000;
    case (a[5:2])
      4'b0000: uop = 4'b0001;
      4'b0001: uop = 4'b0011;
      default: uop = a[5:2];
    endcase
    return {a[1:0], uop};
  endfunction

  assign rom_data = rom_model(rom_addr);

  function automatic vec_t model(input logic [5:0] ins, input int delay);
    vec_t e;
    logic legal;
    e.instr = ins; e.delay = delay; e.exp_trap = 1'b0; e.exp_code = 2'b00;
    e.exp_exec = 0; e.exp_wb = 1'b0; e.exp_sel = 2'b00; e.exp_ctrl = 6'b0;
    legal = (ins[5:2] == 4'b0000) || (ins[5:2] == 4'b0001) ||
            (ins inside {6'b001100, 6'b010001, 6'b011001, 6'b010101, 6'b011101});
    if (!legal) begin
      e.exp_trap = 1'b1; e.exp_code = 2'b01;
      return e;
    end
    e.exp_ctrl = rom_model(ins);
    if (delay >= TIMEOUT) begin
      e.exp_trap = 1'b1; e.exp_code = 2'b10; e.exp_exec = TIMEOUT;
    end else begin
      e.exp_exec = delay + 1;
      e.exp_wb   = (e.exp_ctrl[3:0] == 4'd1) || (e.exp_ctrl[3:0] == 4'd3);
      e.exp_sel  = e.exp_wb ? e.exp_ctrl[5:4] : 2'b00;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drives one instruction from an IDLE negedge and observes it until IDLE or TRAP.
  task automatic run_txn(input logic [5:0] ins, input int delay, output obs_t o);
    o.done = 0; o.rom_addr = 0; o.ctrl = 0; o.unstable = 0; o.exec_cycles = 0;
    o.wb_cnt = 0; o.wb_sel = 0; o.trap = 0; o.trap_code = 0; o.cycles = 0; o.retired = 0;
    instr = ins;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    instr = 6'($urandom);
    o.rom_addr = rom_addr;
    for (int c = 0; c < 4 * TIMEOUT; c++) begin
      if (instr_ready) begin
        o.done = 1; o.retired = retired_cnt;
        break;
      end
      if (trap) begin
        o.done = 1; o.trap = 1; o.trap_code = trap_code;
        break;
      end
      if (exec_valid) begin
        if (o.exec_cycles == 0) o.ctrl = exec_ctrl;
        else if (exec_ctrl !== o.ctrl) o.unstable = 1;
        o.exec_cycles++;
        exec_ready = (o.exec_cycles == delay + 1);
      end else begin
        exec_ready = 1'($urandom);
      end
      if (wb_en) begin
        o.wb_cnt++; o.wb_sel = wb_sel;
      end
      instr_valid = 1'($urandom);
      trap_clr = 1'($urandom);
      o.cycles++;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    exec_ready = 1'b0;
    trap_clr = 1'b0;
  endtask

  task automatic clear_trap(input string tag, input logic [1:0] code);
    instr_valid = 1'b1;
    instr = 6'b000000;
    repeat (3) begin
      @(negedge clk);
      check({tag, " trap_held"}, 32'(trap), 32'(1));
      check({tag, " trap_code_held"}, 32'(trap_code), 32'(code));
      check({tag, " no_accept"}, 32'(instr_ready), 32'(0));
      check({tag, " no_exec"}, 32'(exec_valid), 32'(0));
    end
    instr_valid = 1'b0;
    trap_clr = 1'b1;
    @(negedge clk);
    trap_clr = 1'b0;
    check({tag, " clr_trap"}, 32'(trap), 32'(0));
    check({tag, " clr_code"}, 32'(trap_code), 32'(0));
    check({tag, " clr_ready"}, 32'(instr_ready), 32'(1));
    check({tag, " clr_busy"}, 32'(busy), 32'(0));
  endtask

  task automatic apply(input vec_t v, input string tag);
    obs_t o;
    int exp_cycles;
    run_txn(v.instr, v.delay, o);
    check({tag, " done"}, 32'(o.done), 32'(1));
    check({tag, " rom_addr"}, 32'(o.rom_addr), 32'(v.instr));
    check({tag, " trap"}, 32'(o.trap), 32'(v.exp_trap));
    check({tag, " trap_code"}, 32'(o.trap_code), 32'(v.exp_code));
    check({tag, " exec_cycles"}, 32'(o.exec_cycles), 32'(v.exp_exec));
    check({tag, " wb_cnt"}, 32'(o.wb_cnt), v.exp_wb ? 32'd1 : 32'd0);
    if (v.exp_wb) check({tag, " wb_sel"}, 32'(o.wb_sel), 32'(v.exp_sel));
    if (v.exp_exec > 0) begin
      check({tag, " exec_ctrl"}, 32'(o.ctrl), 32'(v.exp_ctrl));
      check({tag, " ctrl_stable"}, 32'(o.unstable), 32'(0));
    end
    exp_cycles = 1 + v.exp_exec + (v.exp_wb ? 1 : 0);
    check({tag, " cycles"}, 32'(o.cycles), 32'(exp_cycles));
    if (!v.exp_trap) begin
      exp_retired = exp_retired + 1'b1;
      check({tag, " retired"}, 32'(o.retired), 32'(exp_retired));
    end else begin
      clear_trap(tag, v.exp_code);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    vec_t v;
    logic [5:0] ins;
    int delay;

    //        instr      dly  trap  code   exec wb  sel    ctrl
    tbl[0] = '{6'b000010, 0,  1'b0, 2'b00, 1,   1'b1, 2'b10, 6'b100001};
    tbl[1] = '{6'b010001, 3,  1'b0, 2'b00, 4,   1'b0, 2'b00, 6'b001000};
    tbl[2] = '{6'b001000, 0,  1'b1, 2'b01, 0,   1'b0, 2'b00, 6'b000000};
    tbl[3] = '{6'b000111, 15, 1'b0, 2'b00, 16,  1'b1, 2'b11, 6'b110011};
    tbl[4] = '{6'b011001, 99, 1'b1, 2'b10, 16,  1'b0, 2'b00, 6'b010110};
    tbl[5] = '{6'b001100, 0,  1'b0, 2'b00, 1,   1'b1, 2'b00, 6'b000011};
    tbl[6] = '{6'b111111, 0,  1'b1, 2'b01, 0,   1'b0, 2'b00, 6'b000000};
    tbl[7] = '{6'b011101, 2,  1'b0, 2'b00, 3,   1'b0, 2'b00, 6'b010111};
    tbl[8] = '{6'b010101, 16, 1'b1, 2'b10, 16,  1'b0, 2'b00, 6'b010101};

    rst = 1'b1; instr_valid = 1'b0; instr = '0; exec_ready = 1'b0; trap_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_retired = '0;
    check("reset instr_ready", 32'(instr_ready), 32'(1));
    check("reset busy", 32'(busy), 32'(0));
    check("reset retired", 32'(retired_cnt), 32'(0));
    check("reset trap_code", 32'(trap_code), 32'(0));
    check("reset trap", 32'(trap), 32'(0));
    check("reset exec_valid", 32'(exec_valid), 32'(0));
    check("reset wb_en", 32'(wb_en), 32'(0));
    check("reset rom_addr", 32'(rom_addr), 32'(0));

    for (int i = 0; i < 9; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of EXEC.
    instr = 6'b000010; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check("midexec exec_valid", 32'(exec_valid), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_retired = '0;
    check("midexec rst exec_valid", 32'(exec_valid), 32'(0));
    check("midexec rst busy", 32'(busy), 32'(0));
    check("midexec rst wb_en", 32'(wb_en), 32'(0));
    check("midexec rst instr_ready", 32'(instr_ready), 32'(1));
    check("midexec rst retired", 32'(retired_cnt), 32'(0));
    @(negedge clk);
    check("midexec no_wb", 32'(wb_en), 32'(0));

    // Back-to-back sub instructions wrap the retire counter.
    for (int i = 0; i < 256; i++) apply(model(6'b000101, 0), "wrap");
    check("wrap retired_zero", 32'(retired_cnt), 32'(0));

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 6))
          0, 1:    ins = {3'b000, 3'($urandom)};
          2:       ins = 6'b001100;
          3:       ins = 6'b010001;
          4:       ins = 6'b011001;
          5:       ins = 6'b010101;
          default: ins = 6'b011101;
        endcase
      end else begin
        ins = 6'($urandom);
      end
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: delay = $urandom_range(0, 3);
        6:                delay = TIMEOUT - 1;
        7:                delay = TIMEOUT;
        default:          delay = $urandom_range(0, TIMEOUT + 2);
      endcase
      v = model(ins, delay);
      apply(v, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
